// File: rtl/clock_set_ctrl.sv
// Mode/increment push-button controller for setting a calendar clock.
// Synchronizes and debounces two buttons, walks the set fields and emits one-cycle adjust pulses.
module clock_set_ctrl #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned RATE_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sc,
  output logic       mn,
  output logic       hrs,
  output logic       dt,
  output logic       mon,
  output logic       yr,
  output logic [2:0] field,
  output logic       setting
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = $clog2(RATE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    SEC  = 3'd1,
    MIN  = 3'd2,
    HR   = 3'd3,
    DATE = 3'd4,
    MON  = 3'd5,
    YEAR = 3'd6
  } state_e;

  // Bit 0 is the mode button, bit 1 the increment button.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         db_q, db_d, db_prev_q;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  state_e        state_q, state_d;
  logic          setting_q, setting_d;
  logic [5:0]    pulse_q, pulse_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rate_cnt_q, rate_cnt_d;
  logic          rpt_arm_q, rpt_arm_d;
  logic          rpt_on_q, rpt_on_d;
  logic [TW-1:0] idle_q, idle_d;

  logic       mode_rise, inc_rise, any_edge, in_set, fire;
  logic [2:0] fld_idx;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      deb_cnt_q  <= '0;
      state_q    <= RUN;
      setting_q  <= 1'b0;
      pulse_q    <= '0;
      hold_cnt_q <= '0;
      rate_cnt_q <= '0;
      rpt_arm_q  <= 1'b0;
      rpt_on_q   <= 1'b0;
      idle_q     <= '0;
    end else begin
      sync1_q    <= {btn_inc, btn_mode};
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      setting_q  <= setting_d;
      pulse_q    <= pulse_d;
      hold_cnt_q <= hold_cnt_d;
      rate_cnt_q <= rate_cnt_d;
      rpt_arm_q  <= rpt_arm_d;
      rpt_on_q   <= rpt_on_d;
      idle_q     <= idle_d;
    end
  end

  // Debounce: accept a new level once it has differed from db for DEB_CYCLES samples.
  always_comb begin
    db_d      = db_q;
    deb_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != db_q[b]) begin
        if (deb_cnt_q[b] >= DW'(DEB_CYCLES - 1)) begin
          db_d[b] = sync2_q[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  assign mode_rise = db_q[0] & ~db_prev_q[0];
  assign inc_rise  = db_q[1] & ~db_prev_q[1];
  assign any_edge  = |(db_q ^ db_prev_q);
  assign in_set    = state_q inside {SEC, MIN, HR, DATE, MON, YEAR};
  assign fld_idx   = state_q - 3'd1;

  // Field walk, single/auto-repeat pulses and idle timeout; mode advance has priority.
  always_comb begin
    state_d    = state_q;
    pulse_d    = '0;
    hold_cnt_d = '0;
    rate_cnt_d = '0;
    rpt_arm_d  = 1'b0;
    rpt_on_d   = 1'b0;
    idle_d     = '0;
    fire       = 1'b0;

    if (!in_set) begin
      state_d = (state_q == RUN && mode_rise) ? SEC : RUN;
    end else if (mode_rise) begin
      state_d = (state_q == YEAR) ? RUN : state_e'(state_q + 3'd1);
    end else begin
      if (inc_rise) begin
        fire      = 1'b1;
        rpt_arm_d = 1'b1;
      end else if (rpt_arm_q && db_q[1]) begin
        rpt_arm_d  = 1'b1;
        rpt_on_d   = rpt_on_q;
        hold_cnt_d = hold_cnt_q;
        rate_cnt_d = rate_cnt_q;
        if (!rpt_on_q) begin
          if (hold_cnt_q >= HW'(HOLD_CYCLES - 1)) begin
            fire       = 1'b1;
            rpt_on_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end else if (rate_cnt_q >= RW'(RATE_CYCLES - 1)) begin
          fire       = 1'b1;
          rate_cnt_d = '0;
        end else begin
          rate_cnt_d = rate_cnt_q + RW'(1);
        end
      end

      if (fire) begin
        pulse_d[fld_idx] = 1'b1;
      end

      if (!(any_edge || fire)) begin
        if (idle_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = RUN;
          rpt_arm_d  = 1'b0;
          rpt_on_d   = 1'b0;
          hold_cnt_d = '0;
          rate_cnt_d = '0;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
    end

    setting_d = (state_d != RUN);
  end

  assign field   = state_q;
  assign setting = setting_q;
  assign {yr, mon, dt, hrs, mn, sc} = pulse_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed plus randomized bench for clock_set_ctrl against an edge-indexed behavioural model.
module tb_clock_set_ctrl;

  localparam int DEB     = 4;
  localparam int HOLD    = 16;
  localparam int RATE    = 8;
  localparam int TIMEOUT = 64;
  localparam int NMAX    = 8192;

  logic       clk = 1'b0;
  logic       res;
  logic       btn_mode, btn_inc;
  logic       sc, mn, hrs, dt, mon, yr;
  logic [2:0] field;
  logic       setting;

  clock_set_ctrl #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .RATE_CYCLES   (RATE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk     (clk),
    .res     (res),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .sc      (sc),
    .mn      (mn),
    .hrs     (hrs),
    .dt      (dt),
    .mon     (mon),
    .yr      (yr),
    .field   (field),
    .setting (setting)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: input/debounced history by edge number, plus field and repeat bookkeeping.
  int   n = 0;
  int   rst_edge = 0;
  logic want_res = 1'b0;
  logic hm [NMAX];
  logic hi [NMAX];
  logic dm [NMAX];
  logic di [NMAX];
  int   mstate = 0;
  int   mpulse = 0;
  int   armed = 0;
  int   p0 = 0;
  int   last_act = 0;

  // Observation helpers.
  int   pc [6];
  int   hq [$];
  int   chg_edge = 0;
  logic [2:0] prev_field = 3'd0;

  function automatic logic in_at(input int sel, input int k);
    if (k <= rst_edge) return 1'b0;
    return (sel == 0) ? hm[k] : hi[k];
  endfunction

  function automatic logic db_at(input int sel, input int k);
    if (k <= rst_edge) return 1'b0;
    return (sel == 0) ? dm[k] : di[k];
  endfunction

  task automatic model_reset();
    mstate = 0;
    mpulse = 0;
    armed  = 0;
  endtask

  task automatic model_edge();
    logic prev, diff, mr, ir, ae, fire;
    int   d;
    for (int s = 0; s < 2; s++) begin
      prev = db_at(s, n - 1);
      diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (in_at(s, n - 2 - j) == prev) diff = 1'b0;
      end
      if (s == 0) dm[n] = diff ? ~prev : prev;
      else        di[n] = diff ? ~prev : prev;
    end
    mr = db_at(0, n - 1) & ~db_at(0, n - 2);
    ir = db_at(1, n - 1) & ~db_at(1, n - 2);
    ae = (db_at(0, n - 1) != db_at(0, n - 2)) || (db_at(1, n - 1) != db_at(1, n - 2));
    mpulse = 0;
    fire   = 1'b0;
    if (mstate == 0) begin
      if (mr) mstate = 1;
      armed    = 0;
      last_act = n;
    end else if (mr) begin
      mstate   = (mstate == 6) ? 0 : mstate + 1;
      armed    = 0;
      last_act = n;
    end else begin
      if (ir) begin
        fire  = 1'b1;
        armed = 1;
        p0    = n;
      end else if (armed != 0 && db_at(1, n - 1)) begin
        d = n - p0;
        if (d == HOLD || (d > HOLD && ((d - HOLD) % RATE) == 0)) fire = 1'b1;
      end else begin
        armed = 0;
      end
      if (fire) mpulse = mstate;
      if (ae || fire) last_act = n;
      else if (n - last_act >= TIMEOUT) begin
        mstate = 0;
        armed  = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    logic [5:0] exp_p;
    exp_p = (mpulse == 0) ? 6'd0 : 6'(1 << (mpulse - 1));
    chk("field", 32'(field), 32'(mstate));
    chk("setting", 32'(setting), 32'(mstate != 0));
    chk("pulses", 32'({yr, mon, dt, hrs, mn, sc}), 32'(exp_p));
  endtask

  task automatic observe();
    logic [5:0] pv;
    pv = {yr, mon, dt, hrs, mn, sc};
    for (int b = 0; b < 6; b++) if (pv[b] === 1'b1) pc[b]++;
    if (hrs === 1'b1) hq.push_back(n);
    if (field !== prev_field) chg_edge = n;
    prev_field = field;
  endtask

  // One clock: drive at the falling edge, model and compare just after the rising edge.
  task automatic cyc(input logic m, input logic i);
    @(negedge clk);
    if (want_res && !res) rst_edge = n;
    res      = want_res;
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    n++;
    if (n >= NMAX - 2) begin
      $display("FAIL edge_budget: observed %0d expected below %0d", n, NMAX - 2);
      $fatal(1);
    end
    hm[n] = m;
    hi[n] = i;
    if (res) model_edge();
    #1;
    check_all();
    observe();
  endtask

  task automatic hold(input logic m, input logic i, input int len);
    repeat (len) cyc(m, i);
  endtask

  task automatic async_reset();
    #2;
    res      = 1'b0;
    want_res = 1'b0;
    model_reset();
    #1;
    chk("rst_field", 32'(field), 32'd0);
    chk("rst_setting", 32'(setting), 32'd0);
    chk("rst_pulses", 32'({yr, mon, dt, hrs, mn, sc}), 32'd0);
  endtask

  initial begin
    int c0, c1, t;
    int exp_off [6];
    logic m, i;
    int len;

    exp_off = '{0, HOLD, HOLD + RATE, HOLD + 2 * RATE, HOLD + 3 * RATE, HOLD + 4 * RATE};
    for (int b = 0; b < 6; b++) pc[b] = 0;
    res      = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

    hold(0, 0, 3);
    want_res = 1'b1;
    hold(0, 0, 5);

    // Seven mode presses walk every field and return to RUN.
    for (int k = 1; k <= 7; k++) begin
      hold(1, 0, 10);
      hold(0, 0, 10);
      chk("mode_seq", 32'(field), 32'(k % 7));
    end

    // Short glitch is rejected; a 6-cycle press is accepted with fixed latency.
    hold(1, 0, 3);
    hold(0, 0, 15);
    chk("glitch", 32'(field), 32'd0);
    t = n + 1;
    hold(1, 0, 6);
    hold(0, 0, 15);
    chk("deb_field", 32'(field), 32'd1);
    chk("deb_latency", 32'(chg_edge - t + 1), 32'(2 + DEB + 1));

    // Single increment in MIN.
    hold(1, 0, 8);
    hold(0, 0, 12);
    chk("to_min", 32'(field), 32'd2);
    c0 = pc[1];
    hold(0, 1, 10);
    hold(0, 0, 15);
    chk("mn_count", 32'(pc[1] - c0), 32'd1);

    // Auto-repeat in HR.
    hold(1, 0, 8);
    hold(0, 0, 12);
    chk("to_hr", 32'(field), 32'd3);
    hq.delete();
    hold(0, 1, 55);
    hold(0, 0, 20);
    chk("rep_count", 32'(hq.size()), 32'd6);
    for (int k = 0; k < 6 && k < hq.size(); k++) chk("rep_offset", 32'(hq[k] - hq[0]), 32'(exp_off[k]));

    // Simultaneous press in DATE: mode wins, increment discarded.
    hold(1, 0, 8);
    hold(0, 0, 12);
    chk("to_date", 32'(field), 32'd4);
    c0 = pc[3];
    c1 = pc[4];
    hold(1, 1, 10);
    hold(0, 0, 15);
    chk("simul_field", 32'(field), 32'd5);
    chk("simul_pulses", 32'((pc[3] - c0) + (pc[4] - c1)), 32'd0);

    // Idle timeout in YEAR.
    hold(1, 0, 8);
    hold(0, 0, 12);
    chk("to_year", 32'(field), 32'd6);
    while (n < last_act + TIMEOUT - 1) cyc(0, 0);
    chk("pre_timeout", 32'(field), 32'd6);
    cyc(0, 0);
    chk("timeout", 32'(field), 32'd0);

    // Reset during auto-repeat in YEAR.
    for (int k = 0; k < 6; k++) begin
      hold(1, 0, 8);
      hold(0, 0, 12);
    end
    chk("to_year2", 32'(field), 32'd6);
    c0 = pc[5];
    hold(0, 1, 30);
    async_reset();
    hold(0, 1, 4);
    want_res = 1'b1;
    hold(0, 1, 20);
    hold(0, 0, 10);
    chk("yr_count", 32'(pc[5] - c0), 32'd2);

    // Reset mid-debounce with mode held: debounce restarts after release.
    hold(1, 0, 3);
    async_reset();
    hold(1, 0, 3);
    want_res = 1'b1;
    t = n + 1;
    hold(1, 0, 12);
    chk("rst_deb_field", 32'(field), 32'd1);
    chk("rst_deb_latency", 32'(chg_edge - t + 1), 32'(2 + DEB + 1));
    hold(0, 0, 10);

    // Randomized button activity, including long idle stretches.
    repeat (120) begin
      m   = 1'($urandom_range(0, 1));
      i   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(1, 25));
      hold(m, i, len);
    end
    hold(0, 0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable samples needed to accept a button level change.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles btn_inc must stay held before auto-repeat starts.
REQ-003 Parameter RATE_CYCLES, default 8: auto-repeat pulse period, in cycles.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: idle cycles in a set state before the block returns to RUN.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 res  input  1  reset; asynchronous, active-low.
REQ-007 btn_mode  input  1  raw mode push-button, asynchronous to clk, active-high.
REQ-008 btn_inc  input  1  raw increment push-button, asynchronous to clk, active-high.
REQ-009 sc, mn, hrs, dt, mon, yr  output  1 each  one-cycle adjust pulses to the calendar counter: seconds clear, minute, hour, date, month and year increment.
REQ-010 field  output  3  current state encoding: 0=RUN, 1=SEC, 2=MIN, 3=HR, 4=DATE, 5=MON, 6=YEAR.
REQ-011 setting  output  1  high whenever field is not RUN.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Each synchronized button SHALL feed its own debouncer, with register db and a counter.
REQ-014 Debouncer rule: db SHALL take the new synchronized value on the edge where that value has differed from db for DEB_CYCLES consecutive edges.
REQ-015 Debouncer counter: any sample equal to db SHALL clear the counter.
REQ-016 A rise on db_mode SHALL advance the FSM on the next edge: RUN->SEC->MIN->HR->DATE->MON->YEAR->RUN.
REQ-017 A rise on db_inc in a set state SHALL assert the pulse for the current field for exactly one cycle, on the edge after the rise. Field-to-pulse map: SEC->sc, MIN->mn, HR->hrs, DATE->dt, MON->mon, YEAR->yr.
REQ-018 In RUN, db_inc rises and held levels SHALL produce no pulse.
REQ-019 At most one of sc, mn, hrs, dt, mon, yr SHALL be high in any cycle.
REQ-020 Auto-repeat start: while db_inc stays high in a set state, one repeat pulse SHALL fire HOLD_CYCLES cycles after the initial pulse.
REQ-021 Auto-repeat continuation: further pulses SHALL fire every RATE_CYCLES cycles until db_inc falls.
REQ-022 A fall of db_inc SHALL clear the hold/repeat counter immediately, with no further pulses.
REQ-023 If db_mode and db_inc rise on the same edge, the mode advance SHALL take effect and the inc event SHALL be discarded (no pulse).
REQ-024 Any mode advance SHALL cancel any active auto-repeat. Repeat SHALL NOT resume in the new field until db_inc falls and rises again.
REQ-025 An idle counter SHALL count cycles in set states and clear on any db_mode or db_inc edge.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL return to RUN with no pulse. Auto-repeat activity counts as activity.
REQ-027 Counter widths SHALL be $clog2(parameter+1). Counters SHALL saturate and never wrap.
REQ-028 All outputs SHALL be registered. Unused field encoding 7 SHALL recover to RUN on the next edge.

Reset
REQ-029 While res=0, the block SHALL hold these values asynchronously: field=0, setting=0, all pulses 0, db registers 0, synchronizers 0, all counters 0.
REQ-030 Reset assertion mid-repeat or mid-debounce SHALL abort the activity with no pulse emitted. After release, a button already held SHALL be debounced afresh from 0.
REQ-031 The first FSM action SHALL be possible no earlier than 2+DEB_CYCLES edges after res rises.

Verification
REQ-032 Mode presses: press btn_mode 7 times, each 10 cycles high and 10 low -> field sequence 1,2,3,4,5,6,0; setting high for fields 1-6; no pulses.
REQ-033 Glitch rejection: btn_mode high for 3 cycles only -> field stays 0; the same button high for 6 cycles -> field=1, reached 2+4+1 edges after the rise.
REQ-034 Single increment: in MIN, press btn_inc for 10 cycles -> exactly one mn pulse, one cycle wide.
REQ-035 Auto-repeat: in HR, hold btn_inc for 50 cycles after debounce -> hrs pulses at offsets 0, 16, 24, 32, 40, 48, and no pulse after release.
REQ-036 Simultaneous press: in DATE, raise both buttons on the same cycle -> field=5 and no dt or mon pulse.
REQ-037 Timeout and reset: in YEAR, idle 64 cycles -> field=0. Separately, assert res=0 during repeat -> all outputs 0 at once and no yr pulse.
